ram_master: RTL and testbench
=============================

RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the word width of host and RAM data.
REQ-002 Parameter ADD_WIDTH, default 10, SHALL set the RAM address width; RAM depth is 1<<ADD_WIDTH words.
REQ-003 Parameter LEN_WIDTH, default 4, SHALL set the burst length field width; a burst carries cmd_len+1 beats (1..16 at default).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid  in  1  host burst command valid.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
REQ-008 cmd_we  in  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr  in  ADD_WIDTH  burst start address.
REQ-010 cmd_len  in  LEN_WIDTH  beats minus one.
REQ-011 wr_valid  in  1  write beat valid.
REQ-012 wr_ready  out  1  write beat accepted when wr_valid&wr_ready.
REQ-013 wr_data  in  DATA_WIDTH  write beat data.
REQ-014 rd_valid  out  1  read beat valid.
REQ-015 rd_ready  in  1  host accepts read beat when rd_valid&rd_ready.
REQ-016 rd_data  out  DATA_WIDTH  read beat data.
REQ-017 rd_last  out  1  marks final beat of a read burst, qualified by rd_valid.
REQ-018 ram_cs / ram_we / ram_oe  out  1 each  RAM chip select, write enable, output enable.
REQ-019 ram_add  out  ADD_WIDTH  RAM address; ram_din  out  DATA_WIDTH  RAM write data.
REQ-020 ram_dout  in  DATA_WIDTH  RAM read data, valid exactly one cycle after a cycle with ram_cs&ram_oe.

Function
REQ-021 FSM states SHALL be IDLE, WRITE, READ, DRAIN; cmd_ready=1 only in IDLE.
REQ-022 IDLE: on cmd handshake, latch addr and beat counter (cmd_len); go WRITE if cmd_we else READ.
REQ-023 WRITE: wr_ready=1; each wr handshake drives ram_cs=1, ram_we=1, ram_oe=0, ram_add=current addr, ram_din=wr_data in the same cycle (combinational pass-through, zero added latency).
REQ-024 WRITE: cycles without wr_valid SHALL drive ram_cs=ram_we=0; after the beat with counter=0, return to IDLE next cycle.
REQ-025 READ: issue one read (ram_cs=1, ram_oe=1, ram_we=0) per cycle while credits allow; credits = 2 - (output buffer occupancy + reads in flight).
REQ-026 Returned ram_dout SHALL be written into a 2-entry FIFO tagged with last flag; FIFO head drives rd_valid/rd_data/rd_last; holds stable while rd_valid&!rd_ready.
REQ-027 After last read issued, go DRAIN; DRAIN -> IDLE when FIFO empty and nothing in flight.
REQ-028 Address SHALL increment by 1 per issued beat, wrapping modulo 1<<ADD_WIDTH (0x3FF -> 0x000 at default).
REQ-029 ram_we and ram_oe SHALL never be 1 in the same cycle; ram_cs=0 whenever neither is asserted.
REQ-030 Throughput: with wr_valid or rd_ready held high, one beat per cycle; read latency cmd handshake -> first rd_valid = 3 cycles.
REQ-031 Beats arriving on wr_valid outside WRITE SHALL be ignored (wr_ready=0).

Reset
REQ-032 While rst=1: state IDLE, FIFO and credits cleared, cmd_ready=0, wr_ready=0, rd_valid=0, rd_last=0, rd_data=0, ram_cs/ram_we/ram_oe=0, ram_add=0, ram_din=0; cmd_ready=1 first cycle after rst drops.
REQ-033 rst mid-burst SHALL abort the burst; no further RAM access occurs and in-flight read data is discarded.

Structure
REQ-034 FSM state encoding and default parameter constants SHALL live in shared package ram_pkg.
REQ-035 The 2-entry read FIFO SHALL be sub-module ram_rd_fifo (DATA_WIDTH+1 bits wide, occupancy output).

Verification
REQ-036 Write burst addr 0x0A len 0, data 1737075661 -> one cycle ram_cs=ram_we=1, ram_add=0x0A; then read 0x0A returns 1737075661 with rd_last=1.
REQ-037 Write burst addr 0x3FE len 3, data 1..4 -> ram_add 0x3FE,0x3FF,0x000,0x001; read-back returns 1,2,3,4, rd_last only on 4.
REQ-038 Read burst len 7 with rd_ready=0 for 10 cycles -> at most 2 reads issued, rd_data stable; release -> all 8 beats in order, no loss.
REQ-039 Write burst len 3 with wr_valid gapped every other cycle -> RAM writes only on handshake cycles, 4 writes total.
REQ-040 rst asserted on 2nd beat of read burst len 5 -> all outputs at reset values next cycle; subsequent read 0x49 returns correct data.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and default constants for the burst RAM master.
package ram_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADD_WIDTH_DEF  = 10;
  localparam int unsigned LEN_WIDTH_DEF  = 4;
  localparam int unsigned FIFO_DEPTH     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/ram_rd_fifo.sv
// Two-entry read-return FIFO; the head entry is presented directly to the host.
module ram_rd_fifo #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  // Storage, pointers and occupancy; callers never push when full or pop when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head      = mem[rd_ptr];
  assign occupancy = count;

endmodule

// File: rtl/ram_master.sv
// Burst host-to-synchronous-RAM master: pass-through writes, credit-limited
// pipelined reads returned through a two-entry FIFO.
module ram_master
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADD_WIDTH  = ADD_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADD_WIDTH-1:0]  cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADD_WIDTH-1:0]  ram_add,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  state_t                 state, state_d;
  logic [ADD_WIDTH-1:0]   addr, addr_d;
  logic [LEN_WIDTH-1:0]   cnt, cnt_d;
  logic                   inflight, inflight_d;
  logic                   inflight_last, inflight_last_d;

  logic [1:0]             occ;
  logic [DATA_WIDTH:0]    head;
  logic                   pop;
  logic [2:0]             used_c;
  logic                   credit_c;

  // Read-return buffer; each entry carries the burst-last flag above the data.
  ram_rd_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, ram_dout}),
    .pop       (pop),
    .head      (head),
    .occupancy (occ)
  );

  // Host read side; everything is forced low while reset is held.
  assign rd_valid = !rst && (occ != 2'd0);
  assign rd_data  = rd_valid ? head[DATA_WIDTH-1:0] : '0;
  assign rd_last  = rd_valid && head[DATA_WIDTH];
  assign pop      = rd_valid && rd_ready;

  // A beat popped this cycle frees its slot for a read issued this cycle.
  assign used_c   = 3'(occ) + 3'(inflight) - 3'(pop);
  assign credit_c = used_c < 3'(FIFO_DEPTH);

  // State, burst address/counter and read-pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      cnt           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_d;
      addr          <= addr_d;
      cnt           <= cnt_d;
      inflight      <= inflight_d;
      inflight_last <= inflight_last_d;
    end
  end

  // Next-state and RAM/host strobes.
  always_comb begin
    state_d         = state;
    addr_d          = addr;
    cnt_d           = cnt;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    cmd_ready       = 1'b0;
    wr_ready        = 1'b0;
    ram_cs          = 1'b0;
    ram_we          = 1'b0;
    ram_oe          = 1'b0;
    ram_add         = '0;
    ram_din         = '0;
    if (!rst) begin
      ram_add = addr;
      case (state)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            addr_d  = cmd_addr;
            cnt_d   = cmd_len;
            state_d = cmd_we ? WRITE : READ;
          end
        end
        WRITE: begin
          wr_ready = 1'b1;
          if (wr_valid) begin
            ram_cs  = 1'b1;
            ram_we  = 1'b1;
            ram_din = wr_data;
            addr_d  = addr + 1'b1;
            cnt_d   = cnt - 1'b1;
            if (cnt == '0) begin
              state_d = IDLE;
            end
          end
        end
        READ: begin
          if (credit_c) begin
            ram_cs          = 1'b1;
            ram_oe          = 1'b1;
            inflight_d      = 1'b1;
            inflight_last_d = (cnt == '0);
            addr_d          = addr + 1'b1;
            cnt_d           = cnt - 1'b1;
            if (cnt == '0) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((occ == 2'd0) && !inflight) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// Self-checking bench for ram_master: behavioural RAM, reference memory image
// and directed plus randomized bursts.
module tb_ram_master;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned LW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          ram_cs, ram_we, ram_oe;
  logic [AW-1:0] ram_add;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int            wr_strobes = 0;
  int            rd_strobes = 0;
  logic          bad_strobe = 1'b0;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  ram_master #(
    .DATA_WIDTH (DW),
    .ADD_WIDTH  (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_add   (ram_add),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears one cycle after cs&oe.
  always @(posedge clk) begin
    if (ram_cs && ram_we) ram_mem[ram_add] <= ram_din;
    if (ram_cs && ram_oe) ram_dout <= ram_mem[ram_add];
  end

  // Access counters and illegal-strobe detector.
  always @(posedge clk) begin
    if (ram_cs && ram_we) wr_strobes <= wr_strobes + 1;
    if (ram_cs && ram_oe) rd_strobes <= rd_strobes + 1;
    if ((ram_we && ram_oe) || (ram_cs && !ram_we && !ram_oe)) bad_strobe <= 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 64'({cmd_ready, wr_ready, rd_valid, rd_last, ram_cs, ram_we, ram_oe}), 64'd0);
    check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    check({tag, "_ram_add"}, 64'(ram_add), 64'd0);
    check({tag, "_ram_din"}, 64'(ram_din), 64'd0);
  endtask

  // gap_mode: 0 = wr_valid held high, 1 = idle cycle between beats, 2 = random idles.
  task automatic do_write(input logic [AW-1:0] a, input int len, input logic [DW-1:0] d [$],
                          input int gap_mode);
    int w0;
    w0 = wr_strobes;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = a; cmd_len = LW'(len);
    #1 check("wr_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(1) == 1)) begin
        wr_valid = 1'b0;
        #1;
        check("wr_gap_strobe", 64'({ram_cs, ram_we}), 64'd0);
        check("wr_gap_ready", 64'(wr_ready), 64'd1);
        @(negedge clk);
      end
      wr_valid = 1'b1;
      wr_data  = d[i];
      #1;
      check("wr_strobe", 64'({ram_cs, ram_we, ram_oe}), 64'b110);
      check("wr_add", 64'(ram_add), 64'(AW'(32'(a) + 32'(i))));
      check("wr_din", 64'(ram_din), 64'(d[i]));
      ref_mem[AW'(32'(a) + 32'(i))] = d[i];
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    check("wr_back_idle", 64'(cmd_ready), 64'd1);
    check("wr_count", 64'(wr_strobes - w0), 64'(len + 1));
  endtask

  // stall: cycles of rd_ready=0 after the command; rdy_rand: random rd_ready afterwards.
  task automatic do_read(input logic [AW-1:0] a, input int len, input int stall,
                         input bit rdy_rand, input bit chk_lat);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] prev_d;
    bit            prev_stall;
    int            k, cyc, r0;
    for (int i = 0; i <= len; i++) exp_q.push_back(ref_mem[AW'(32'(a) + 32'(i))]);
    k = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0;
    r0 = rd_strobes;
    @(negedge clk);
    rd_ready = 1'b0; cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = a; cmd_len = LW'(len);
    #1 check("rd_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    while (k <= len && cyc < 400) begin
      rd_ready = (cyc < stall) ? 1'b0 : (rdy_rand ? 1'($urandom_range(1)) : 1'b1);
      #1;
      if (chk_lat && cyc == 1) check("rd_latency_early", 64'(rd_valid), 64'd0);
      if (chk_lat && cyc == 2) check("rd_latency", 64'(rd_valid), 64'd1);
      if (stall > 0 && cyc == stall - 1)
        check("rd_stall_issue_limit", 64'((rd_strobes - r0) <= 2), 64'd1);
      if (prev_stall) begin
        check("rd_hold_valid", 64'(rd_valid), 64'd1);
        check("rd_hold_data", 64'(rd_data), 64'(prev_d));
      end
      if (rd_valid) begin
        check("rd_data", 64'(rd_data), 64'(exp_q[k]));
        check("rd_last", 64'(rd_last), 64'(k == len));
        prev_stall = !rd_ready;
        prev_d     = rd_data;
        if (rd_ready) k++;
      end else begin
        prev_stall = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    check("rd_complete", 64'(k), 64'(len + 1));
    for (int i = 0; i < 10 && !cmd_ready; i++) @(negedge clk);
    #1;
    check("rd_back_idle", 64'(cmd_ready), 64'd1);
    check("rd_issue_count", 64'(rd_strobes - r0), 64'(len + 1));
  endtask

  initial begin
    logic [DW-1:0] dq [$];
    int            r_snap, n;
    bit            seen;
    logic [AW-1:0] ra;

    // Reset state
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    #1 check("reset_release_cmd_ready", 64'(cmd_ready), 64'd1);

    // Fill the whole RAM with random data through 16-beat write bursts
    for (int b = 0; b < int'(DEPTH / 16); b++) begin
      dq = {};
      for (int i = 0; i < 16; i++) dq.push_back(DW'($urandom));
      do_write(AW'(b * 16), 15, dq, 0);
    end

    // Single-beat write then read-back with latency check
    dq = {};
    dq.push_back(32'd1737075661);
    do_write(10'h00A, 0, dq, 0);
    do_read(10'h00A, 0, 0, 1'b0, 1'b1);

    // Address wrap across the top of memory
    dq = {};
    for (int i = 1; i <= 4; i++) dq.push_back(DW'(i));
    do_write(10'h3FE, 3, dq, 0);
    do_read(10'h3FE, 3, 0, 1'b0, 1'b1);

    // Back-pressure: host stalls for 10 cycles
    do_read(AW'($urandom), 7, 10, 1'b0, 1'b0);

    // Write beats gapped every other cycle
    dq = {};
    for (int i = 0; i < 4; i++) dq.push_back(DW'($urandom));
    do_write(10'h020, 3, dq, 1);
    do_read(10'h020, 3, 0, 1'b0, 1'b0);

    // Reset during the second beat of a read burst
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h100; cmd_len = LW'(5);
    @(negedge clk);
    cmd_valid = 1'b0; rd_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (rd_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("rst_first_beat_seen", 64'(seen), 64'd1);
    rst = 1'b1;
    #1 check_reset_outputs("rst_mid_burst");
    @(negedge clk);
    #1 check_reset_outputs("rst_mid_burst_held");
    r_snap = rd_strobes;
    rst = 1'b0; rd_ready = 1'b0;
    #1;
    check("rst_release_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_release_rd_valid", 64'(rd_valid), 64'd0);
    repeat (4) @(negedge clk);
    #1;
    check("rst_no_further_access", 64'(rd_strobes - r_snap), 64'd0);
    check("rst_no_stale_data", 64'(rd_valid), 64'd0);
    do_read(10'h049, 0, 0, 1'b0, 1'b1);

    // Randomized mixed traffic
    for (int t = 0; t < 40; t++) begin
      ra = AW'($urandom);
      n  = int'($urandom_range(15));
      if ($urandom_range(1) == 1) begin
        dq = {};
        for (int i = 0; i <= n; i++) dq.push_back(DW'($urandom));
        do_write(ra, n, dq, 2);
      end else begin
        do_read(ra, n, int'($urandom_range(4)), 1'b1, 1'b0);
      end
    end

    check("we_oe_exclusive", 64'(bad_strobe), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
